param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Derived constant AW = $clog2(DEPTH); count and threshold width is AW+1.
REQ-005 One clock and one reset: clk is the single clock, and rst_n is an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 rd_en  input  1  read/pop request.
REQ-011 flush  input  1  synchronous clear of contents.
REQ-012 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-013 af_level  input  AW+1  almost-full threshold.
REQ-014 ae_level  input  AW+1  almost-empty threshold.
REQ-015 rd_data  output  DATA_WIDTH  read word.
REQ-016 rd_valid  output  1  rd_data holds a popped word (FWFT=0) or the head word (FWFT=1).
REQ-017 full, empty  output  1 each  occupancy flags.
REQ-018 almost_full, almost_empty  output  1 each  threshold flags.
REQ-019 count  output  AW+1  occupancy, 0..DEPTH.
REQ-020 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-021 Read is accepted (rd_acc) iff rd_en && !empty.
REQ-022 Write is accepted (wr_acc) iff wr_en && (!full || rd_acc); a write to a full FIFO succeeds when a read is accepted in the same cycle.
REQ-023 Pointers are AW+1 bits wide; the MSB is the wrap bit.
- full when the addresses are equal and the wrap bits differ.
- empty when the pointers are equal.
- Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
REQ-024 count updates next cycle: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-025 almost_full = (count >= af_level) and almost_empty = (count <= ae_level), both combinational from registered count.
REQ-026 FWFT=0: on rd_acc, rd_data is loaded with the head word at the next edge and rd_valid = 1 for exactly that one cycle; otherwise rd_data holds its value and rd_valid = 0.
REQ-027 FWFT=1: rd_data = head word and rd_valid = !empty, combinationally; rd_en pops the head.
REQ-028 A word written while empty is visible in FWFT=1 in the cycle after the write edge.
REQ-029 overflow sets on wr_en && !wr_acc; underflow sets on rd_en && empty. Both hold until clr_err or reset.
REQ-030 clr_err has priority over a same-cycle set.
REQ-031 flush has priority over wr_en/rd_en: at the next edge it zeroes both pointers and count, clears rd_valid, and writes nothing. It does not alter the error flags or rd_data in FWFT=0.
REQ-032 Ordering is strict FIFO; no data is lost or duplicated across pointer wrap.

Reset
REQ-033 On rst_n low, asynchronously:
- pointers = 0, count = 0, empty = 1, full = 0
- rd_valid = 0, rd_data = 0
- overflow = 0, underflow = 0
- almost flags follow count per REQ-025.
REQ-034 Storage array contents are not reset.
REQ-035 Reset asserted mid-operation discards all contents; the first post-reset read returns the first post-reset write.

Structure
REQ-036 Package fifo_pkg holds:
- the read-mode enum (FIFO_STD=0, FIFO_FWFT=1)
- a function computing the pointer/count width from DEPTH.
REQ-037 Sub-module fifo_mem is a DEPTH x DATA_WIDTH register array:
- synchronous write port
- asynchronous read port addressed by the read pointer
- no reset.
REQ-038 param_sync_fifo contains pointers, count, flags, the error logic and the FWFT=0 output register.

Verification (DATA_WIDTH=8, DEPTH=16, af_level=14, ae_level=2)
REQ-039 Reset, then write 0x00..0x0F -> full=1, count=16, almost_full=1 from count 14; a 17th write sets overflow=1 and count stays 16.
REQ-040 FWFT=0, write 0xAB then pulse rd_en -> rd_valid=1 one cycle later with rd_data=0xAB, then empty=1; a further rd_en sets underflow=1, and clr_err clears it.
REQ-041 FWFT=1, write 0x5A into an empty FIFO -> next cycle rd_data=0x5A, rd_valid=1, without rd_en.
REQ-042 Full FIFO, wr_en+rd_en with wr_data=0x99 -> count stays 16, overflow stays 0, and 0x99 is read last after draining.
REQ-043 Write 40 words 0..39 interleaved with reads, keeping count between 3 and 12 -> every read matches a reference queue across pointer wrap.
REQ-044 With count=7, assert flush together with wr_en -> next cycle count=0, empty=1; assert rst_n low mid-burst -> all flags return to their reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
// Holds the read-mode enum and the pointer/count width function.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer and count width: one extra bit over the address width.
    // The extra bit is the wrap bit, and it also lets count reach DEPTH.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, async read.
// Ports: clk, we_i, waddr_i, wdata_i, raddr_i, rdata_o. Not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered or first-word-fall-through read.
// Ports: clk/rst_n, wr_en/wr_data, rd_en, flush, clr_err, af/ae levels;
// rd_data/rd_valid, full/empty, almost flags, count, sticky errors.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         clr_err,
    input  logic [fifo_cnt_w(DEPTH)-1:0] af_level,
    input  logic [fifo_cnt_w(DEPTH)-1:0] ae_level,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic                  empty_w;
    logic                  full_w;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] head;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign rd_acc = rd_en && !empty_w;
    // A full FIFO still takes a write when a pop frees a slot this cycle.
    assign wr_acc = wr_en && (!full_w || rd_acc);
    assign mem_we = wr_acc && !flush;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i(wr_data),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Error flags are independent of flush; clr_err beats a new set.
    always_comb begin
        ovf_d = ovf_q | (wr_en & ~wr_acc);
        udf_d = udf_q | (rd_en & empty_w);
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rvalid_d = rd_acc && !flush;
                rdata_d  = rvalid_d ? head : rdata_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rd_data  = rdata_q;
            assign rd_valid = rvalid_q;
        end else begin : g_fwft
            assign rd_data  = head;
            assign rd_valid = !empty_w;
        end
    endgenerate

    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_q;
    assign almost_full  = (count_q >= af_level);
    assign almost_empty = (count_q <= ae_level);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
